fb_buf_switcher: RTL and testbench
==================================

# fb_buf_switcher

Parametrised frame-buffer swap controller for 2- or 3-buffer SRAM framebuffers. It sits between the gfx write path and the multi-SRAM AXI controller. It tracks which buffer the producer writes and which buffer the display reads. It holds the producer off until its in-flight AXI writes drain, and performs the index exchange on a display vsync edge (double buffer) or lets the producer continue immediately (triple buffer).

## Interface
- NUM_BUFS, 2: buffer count; legal values are 2 and 3 only.
- MAX_OUTSTANDING, 8: maximum number of in-flight producer writes tracked.
- DRAIN_TIMEOUT, 255: maximum cycles spent in DRAIN before forcing progress.
- SYNC_TO_VSYNC, 1: for NUM_BUFS=2 only, the swap waits for a vsync edge; 0 swaps right after drain. Ignored when NUM_BUFS=3.
- VSYNC_ACTIVE, 0: asserted level of cons_vsync.
- BUF_BITS = $clog2(NUM_BUFS) (local); CNT_BITS = $clog2(MAX_OUTSTANDING+1) (local).

- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- swap_req  in  1  level signal; each rising edge requests one swap.
- prod_aw_fire  in  1  producer AW handshake (awvalid && awready).
- prod_b_fire  in  1  producer B handshake (bvalid && bready).
- cons_vsync  in  1  display vsync in the clk domain.
- prod_hold  out  1  high means the producer must not start new writes (gates gfx_ready).
- prod_buf  out  BUF_BITS  buffer index the producer writes.
- cons_buf  out  BUF_BITS  buffer index the display reads.
- switch  out  1  one-cycle pulse in the first cycle new indices are visible.
- busy  out  1  high whenever state != IDLE or a swap is pending.
- outstanding  out  CNT_BITS  current count of in-flight producer writes.
- err  out  1  sticky error flag: counter over/underflow or drain timeout.

## Operation
- Reset values: prod_buf=0, cons_buf=1, ready index=2 (NUM_BUFS=3 only), ready_valid=0, outstanding=0, state=IDLE, pending=0, prod_hold=0, switch=0, busy=0, err=0.
- Edge detection (registered):
  - req_edge = swap_req && !swap_req_q.
  - vs_edge = (cons_vsync==VSYNC_ACTIVE) && (vs_q!=VSYNC_ACTIVE).
  - Both history flops reset to the deasserted level.
- Outstanding counter:
  - +1 on aw_fire only; -1 on b_fire only; unchanged when both fire.
  - aw_fire at MAX_OUTSTANDING: saturate and set err.
  - b_fire at 0: stay at 0 and set err.
- State machine (states IDLE, DRAIN, WAIT_VS, SWAP):
  - IDLE: on req_edge or pending, go to DRAIN, clear pending, clear the timeout counter.
  - DRAIN: when outstanding==0, or the timeout counter reaches DRAIN_TIMEOUT (which also sets err):
    - NUM_BUFS=2 and SYNC_TO_VSYNC=1: go to WAIT_VS.
    - Otherwise: go to SWAP.
  - WAIT_VS: on vs_edge, go to SWAP.
  - SWAP: go to IDLE. Indices update on that clock edge.
- Swap action:
  - NUM_BUFS=2: exchange prod_buf and cons_buf.
  - NUM_BUFS=3: exchange prod_buf and ready; set ready_valid=1. Any older undisplayed ready frame is dropped and becomes the new producer buffer.
- Consumer flip (NUM_BUFS=3 only):
  - Trigger: vs_edge while ready_valid=1, in any state.
  - Action: exchange cons_buf and ready; clear ready_valid.
- Simultaneous events:
  - Swap action and consumer flip in the same cycle (NUM_BUFS=3): new prod=old ready, new cons=old prod, new ready=old cons, ready_valid=0.
  - req_edge while state != IDLE: sets pending. Further edges are absorbed; at most one queued.
  - req_edge in the SWAP cycle: sets pending.
- prod_hold = (state != IDLE), decoded from the registered state.
- prod_buf, cons_buf and ready are always pairwise distinct.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from any input to any output.
- req_edge sampled at cycle T (IDLE): prod_hold rises at T+1. A prod_aw_fire at T is still counted.
- Best case, no outstanding writes and no vsync wait:
  - DRAIN at T+1, SWAP at T+2.
  - New indices, switch=1 and prod_hold=0 all at T+3.
- WAIT_VS adds cycles until vs_edge. vs_edge seen at cycle V gives SWAP at V+1 and new indices at V+2.
- Consumer flip (NUM_BUFS=3): vs_edge sampled at V gives new cons_buf and switch=1 at V+1.
- rst_n asserted mid-operation: all state returns to reset values immediately, with no switch pulse. The outstanding count is lost.

## Test plan
- NUM_BUFS=2, SYNC_TO_VSYNC=0, no outstanding writes, swap_req pulse at T -> prod_hold high T+1..T+2; at T+3 prod_buf=1, cons_buf=0, switch=1 for exactly one cycle.
- NUM_BUFS=2, SYNC_TO_VSYNC=1:
  - Stimulus: 3 aw_fires, then swap_req, then b_fires 20 cycles later, then vsync asserted 100 cycles later.
  - Required: outstanding 3→0; state stays DRAIN until count=0, then WAIT_VS; swap occurs 2 cycles after the vsync edge; err=0.
- NUM_BUFS=3:
  - Stimulus: two swaps with no vsync between them, then one vs_edge.
  - Required: after swap 1 prod=2, ready=0; after swap 2 prod=0, ready=2 (frame from swap 1 dropped); after vs_edge cons=2, ready=1, ready_valid=0.
- NUM_BUFS=3, swap action and vs_edge coincide with prod=0, ready=2 (ready_valid=1), cons=1 -> prod=2, cons=0, ready=1, ready_valid=0.
- Counter and queuing edge cases:
  - aw_fire and b_fire in the same cycle -> count unchanged.
  - b_fire at count 0 -> err=1, count stays 0.
  - 9 aw_fires with MAX_OUTSTANDING=8 -> count saturates at 8, err=1.
  - 3 swap_req edges during DRAIN -> exactly one extra swap.
- DRAIN_TIMEOUT=15 with count stuck at 1 -> err=1 and swap proceeds 16 cycles after entering DRAIN; rst_n pulsed during WAIT_VS -> all outputs return to reset values, no switch pulse.

Source files
------------

// File: rtl/fb_buf_switcher.sv
// Frame-buffer swap controller for 2- or 3-buffer SRAM framebuffers.
// Tracks the producer/display buffer indices, holds the producer off until its
// in-flight AXI writes drain, then exchanges indices (on vsync for double
// buffering, immediately for triple buffering). NUM_BUFS must be 2 or 3.
module fb_buf_switcher #(
  parameter int NUM_BUFS        = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DRAIN_TIMEOUT   = 255,
  parameter int SYNC_TO_VSYNC   = 1,
  parameter bit VSYNC_ACTIVE    = 1'b0,
  localparam int BUF_BITS = $clog2(NUM_BUFS),
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                swap_req,
  input  logic                prod_aw_fire,
  input  logic                prod_b_fire,
  input  logic                cons_vsync,
  output logic                prod_hold,
  output logic [BUF_BITS-1:0] prod_buf,
  output logic [BUF_BITS-1:0] cons_buf,
  output logic                switch,
  output logic                busy,
  output logic [CNT_BITS-1:0] outstanding,
  output logic                err
);

  localparam int TO_BITS = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
  localparam logic [TO_BITS-1:0]  TO_MAX  = TO_BITS'(DRAIN_TIMEOUT);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUTSTANDING);
  localparam bit TRIPLE      = (NUM_BUFS == 3);
  localparam bit USE_VS_WAIT = (NUM_BUFS == 2) && (SYNC_TO_VSYNC != 0);

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT_VS, SWAP} state_t;

  state_t              state_reg, state_next;
  logic                pending_reg, pending_next;
  logic [TO_BITS-1:0]  to_reg, to_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                err_reg, err_next;
  logic [BUF_BITS-1:0] prod_reg, prod_next;
  logic [BUF_BITS-1:0] cons_reg, cons_next;
  logic [BUF_BITS-1:0] ready_reg, ready_next;
  logic                rv_reg, rv_next;
  logic                switch_reg, switch_next;
  logic                swap_req_q_reg, vs_q_reg;
  logic                req_edge, vs_edge, do_swap, flip;
  logic                cnt_err, to_err;

  assign req_edge = swap_req && !swap_req_q_reg;
  assign vs_edge  = (cons_vsync == VSYNC_ACTIVE) && (vs_q_reg != VSYNC_ACTIVE);
  assign do_swap  = (state_reg == SWAP);
  // A displayable frame is handed to the display on the next vsync edge.
  assign flip     = TRIPLE && vs_edge && rv_reg;
  assign err_next = err_reg | cnt_err | to_err;

  // Outstanding-write counter: saturates at both ends and flags misuse.
  always_comb begin
    cnt_next = cnt_reg;
    cnt_err  = 1'b0;
    if (prod_aw_fire && !prod_b_fire) begin
      if (cnt_reg == CNT_MAX) cnt_err = 1'b1;
      else                    cnt_next = cnt_reg + CNT_BITS'(1);
    end else if (prod_b_fire && !prod_aw_fire) begin
      if (cnt_reg == '0) cnt_err = 1'b1;
      else               cnt_next = cnt_reg - CNT_BITS'(1);
    end
  end

  // Swap sequencer next-state: drain writes, optionally wait for vsync, swap.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    to_next      = to_reg;
    to_err       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_edge || pending_reg) begin
          state_next   = DRAIN;
          pending_next = 1'b0;
          to_next      = '0;
        end
      end
      DRAIN: begin
        if (req_edge) pending_next = 1'b1;
        if (cnt_reg == '0 || to_reg == TO_MAX) begin
          // Forced progress with writes still in flight is an error.
          to_err     = (cnt_reg != '0);
          state_next = USE_VS_WAIT ? WAIT_VS : SWAP;
        end else begin
          to_next = to_reg + TO_BITS'(1);
        end
      end
      WAIT_VS: begin
        if (req_edge) pending_next = 1'b1;
        if (vs_edge)  state_next = SWAP;
      end
      SWAP: begin
        if (req_edge) pending_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer index rotation for the swap action and the consumer flip.
  always_comb begin
    prod_next  = prod_reg;
    cons_next  = cons_reg;
    ready_next = ready_reg;
    rv_next    = rv_reg;
    if (!TRIPLE) begin
      if (do_swap) begin
        prod_next = cons_reg;
        cons_next = prod_reg;
      end
    end else if (do_swap && flip) begin
      prod_next  = ready_reg;
      cons_next  = prod_reg;
      ready_next = cons_reg;
      rv_next    = 1'b0;
    end else if (do_swap) begin
      // An older undisplayed ready frame is dropped and reused by the producer.
      prod_next  = ready_reg;
      ready_next = prod_reg;
      rv_next    = 1'b1;
    end else if (flip) begin
      cons_next  = ready_reg;
      ready_next = cons_reg;
      rv_next    = 1'b0;
    end
    switch_next = do_swap || flip;
  end

  // All state registers, returned to reset values asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      to_reg         <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      prod_reg       <= '0;
      cons_reg       <= BUF_BITS'(1);
      ready_reg      <= BUF_BITS'(2);
      rv_reg         <= 1'b0;
      switch_reg     <= 1'b0;
      swap_req_q_reg <= 1'b0;
      vs_q_reg       <= !VSYNC_ACTIVE;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      to_reg         <= to_next;
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
      prod_reg       <= prod_next;
      cons_reg       <= cons_next;
      ready_reg      <= ready_next;
      rv_reg         <= rv_next;
      switch_reg     <= switch_next;
      swap_req_q_reg <= swap_req;
      vs_q_reg       <= cons_vsync;
    end
  end

  assign prod_hold   = (state_reg != IDLE);
  assign busy        = (state_reg != IDLE) || pending_reg;
  assign prod_buf    = prod_reg;
  assign cons_buf    = cons_reg;
  assign switch      = switch_reg;
  assign outstanding = cnt_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_fb_buf_switcher.sv
// Self-checking bench for fb_buf_switcher: three instances cover the
// double-buffer immediate, double-buffer vsync-synchronised and triple-buffer
// configurations. VSYNC is active-low in all instances, so it idles high.
module tb_fb_buf_switcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u2n: 2 buffers, no vsync wait, DRAIN_TIMEOUT=15
  logic a_swap = 0, a_aw = 0, a_b = 0, a_vs = 1;
  logic a_hold, a_sw, a_busy, a_err;
  logic [0:0] a_prod, a_cons;
  logic [3:0] a_out;
  // u2v: 2 buffers, vsync-synchronised
  logic b_swap = 0, b_aw = 0, b_b = 0, b_vs = 1;
  logic b_hold, b_sw, b_busy, b_err;
  logic [0:0] b_prod, b_cons;
  logic [3:0] b_out;
  // u3: 3 buffers
  logic c_swap = 0, c_aw = 0, c_b = 0, c_vs = 1;
  logic c_hold, c_sw, c_busy, c_err;
  logic [1:0] c_prod, c_cons;
  logic [3:0] c_out;

  fb_buf_switcher #(.NUM_BUFS(2), .MAX_OUTSTANDING(8), .DRAIN_TIMEOUT(15),
                    .SYNC_TO_VSYNC(0), .VSYNC_ACTIVE(1'b0)) u2n (
    .clk(clk), .rst_n(rst_n), .swap_req(a_swap), .prod_aw_fire(a_aw),
    .prod_b_fire(a_b), .cons_vsync(a_vs), .prod_hold(a_hold), .prod_buf(a_prod),
    .cons_buf(a_cons), .switch(a_sw), .busy(a_busy), .outstanding(a_out), .err(a_err));

  fb_buf_switcher #(.NUM_BUFS(2), .MAX_OUTSTANDING(8), .DRAIN_TIMEOUT(255),
                    .SYNC_TO_VSYNC(1), .VSYNC_ACTIVE(1'b0)) u2v (
    .clk(clk), .rst_n(rst_n), .swap_req(b_swap), .prod_aw_fire(b_aw),
    .prod_b_fire(b_b), .cons_vsync(b_vs), .prod_hold(b_hold), .prod_buf(b_prod),
    .cons_buf(b_cons), .switch(b_sw), .busy(b_busy), .outstanding(b_out), .err(b_err));

  fb_buf_switcher #(.NUM_BUFS(3), .MAX_OUTSTANDING(8), .DRAIN_TIMEOUT(255),
                    .SYNC_TO_VSYNC(1), .VSYNC_ACTIVE(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .swap_req(c_swap), .prod_aw_fire(c_aw),
    .prod_b_fire(c_b), .cons_vsync(c_vs), .prod_hold(c_hold), .prod_buf(c_prod),
    .cons_buf(c_cons), .switch(c_sw), .busy(c_busy), .outstanding(c_out), .err(c_err));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic aw;
    logic b;
    int   exp_cnt;
    logic exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One u3 swap request; checks the indices that appear three cycles later.
  task automatic swap3(input int ep, input int ec, input int er);
    c_swap = 1'b1;
    tick();
    c_swap = 1'b0;
    tick();
    tick();
    chk("u3_swap_prod", int'(c_prod), ep);
    chk("u3_swap_cons", int'(c_cons), ec);
    chk("u3_swap_ready", 3 - int'(c_prod) - int'(c_cons), er);
    chk("u3_swap_pulse", int'(c_sw), 1);
    tick();
    chk("u3_swap_pulse_end", int'(c_sw), 0);
  endtask

  int sw_cnt;
  int pa;
  int m_cnt;
  bit m_err;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_a_prod", int'(a_prod), 0);  chk("rst_a_cons", int'(a_cons), 1);
    chk("rst_a_hold", int'(a_hold), 0);  chk("rst_a_sw", int'(a_sw), 0);
    chk("rst_a_busy", int'(a_busy), 0);  chk("rst_a_out", int'(a_out), 0);
    chk("rst_a_err", int'(a_err), 0);
    chk("rst_b_prod", int'(b_prod), 0);  chk("rst_b_cons", int'(b_cons), 1);
    chk("rst_c_prod", int'(c_prod), 0);  chk("rst_c_cons", int'(c_cons), 1);
    chk("rst_c_hold", int'(c_hold), 0);  chk("rst_c_busy", int'(c_busy), 0);

    // ---------------- basic 2-buffer swap, no vsync wait ----------------
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    chk("basic_hold_t1", int'(a_hold), 1);
    chk("basic_busy_t1", int'(a_busy), 1);
    chk("basic_prod_t1", int'(a_prod), 0);
    tick();
    chk("basic_hold_t2", int'(a_hold), 1);
    chk("basic_sw_t2", int'(a_sw), 0);
    tick();
    chk("basic_prod_t3", int'(a_prod), 1);
    chk("basic_cons_t3", int'(a_cons), 0);
    chk("basic_sw_t3", int'(a_sw), 1);
    chk("basic_hold_t3", int'(a_hold), 0);
    tick();
    chk("basic_sw_t4", int'(a_sw), 0);

    // ---------------- three request edges during DRAIN ----------------
    a_aw = 1'b1;
    tick();
    a_aw = 1'b0;
    a_swap = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_swap = 1'b0;
      tick();
      a_swap = 1'b1;
      tick();
    end
    a_swap = 1'b0;
    tick();
    chk("queue_hold_in_drain", int'(a_hold), 1);
    a_b = 1'b1;
    tick();
    a_b = 1'b0;
    sw_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_sw) sw_cnt++;
    end
    chk("queue_swap_count", sw_cnt, 2);
    chk("queue_prod", int'(a_prod), 1);
    chk("queue_busy", int'(a_busy), 0);
    chk("queue_err", int'(a_err), 0);

    // ---------------- drain timeout with one write stuck ----------------
    a_aw = 1'b1;
    tick();
    a_aw = 1'b0;
    a_swap = 1'b1;
    tick();
    a_swap = 1'b0;
    repeat (15) tick();
    chk("tmo_err_before", int'(a_err), 0);
    chk("tmo_hold_before", int'(a_hold), 1);
    tick();
    chk("tmo_err_set", int'(a_err), 1);
    chk("tmo_prod_swapstate", int'(a_prod), 1);
    tick();
    chk("tmo_prod_after", int'(a_prod), 0);
    chk("tmo_sw_after", int'(a_sw), 1);
    chk("tmo_out_kept", int'(a_out), 1);
    a_b = 1'b1;
    tick();
    a_b = 1'b0;
    do_reset();

    // ---------------- counter vector table ----------------
    vecs.push_back('{1'b1, 1'b1, 0, 1'b0});
    for (int i = 1; i <= 8; i++) vecs.push_back('{1'b1, 1'b0, i, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 7, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 7, 1'b1});
    foreach (vecs[i]) begin
      a_aw = vecs[i].aw;
      a_b  = vecs[i].b;
      tick();
      chk("vec_cnt", int'(a_out), vecs[i].exp_cnt);
      chk("vec_err", int'(a_err), int'(vecs[i].exp_err));
    end
    a_aw = 1'b0;
    a_b  = 1'b0;
    do_reset();
    a_b = 1'b1;
    tick();
    a_b = 1'b0;
    chk("underflow_cnt", int'(a_out), 0);
    chk("underflow_err", int'(a_err), 1);
    do_reset();

    // ---------------- randomized counter vs reference model ----------------
    m_cnt = 0;
    m_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pa = (i < 150) ? 70 : 30;
      a_aw = ($urandom_range(99) < pa);
      a_b  = ($urandom_range(99) < (100 - pa));
      tick();
      if (a_aw && !a_b) begin
        if (m_cnt == 8) m_err = 1'b1;
        else m_cnt = m_cnt + 1;
      end else if (a_b && !a_aw) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt = m_cnt - 1;
      end
      chk("rnd_cnt", int'(a_out), m_cnt);
      chk("rnd_err", int'(a_err), int'(m_err));
    end
    a_aw = 1'b0;
    a_b  = 1'b0;

    // ---------------- 2-buffer vsync-synchronised swap ----------------
    b_aw = 1'b1;
    repeat (3) tick();
    b_aw = 1'b0;
    chk("vs_out_3", int'(b_out), 3);
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    chk("vs_hold_drain", int'(b_hold), 1);
    repeat (20) tick();
    chk("vs_hold_20", int'(b_hold), 1);
    chk("vs_out_20", int'(b_out), 3);
    b_b = 1'b1;
    tick();
    chk("vs_out_2", int'(b_out), 2);
    tick();
    chk("vs_out_1", int'(b_out), 1);
    tick();
    chk("vs_out_0", int'(b_out), 0);
    b_b = 1'b0;
    sw_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_sw) sw_cnt++;
    end
    chk("vs_no_early_swap", sw_cnt, 0);
    chk("vs_hold_waiting", int'(b_hold), 1);
    chk("vs_prod_waiting", int'(b_prod), 0);
    b_vs = 1'b0;
    tick();
    chk("vs_prod_v1", int'(b_prod), 0);
    chk("vs_hold_v1", int'(b_hold), 1);
    tick();
    chk("vs_prod_v2", int'(b_prod), 1);
    chk("vs_cons_v2", int'(b_cons), 0);
    chk("vs_sw_v2", int'(b_sw), 1);
    chk("vs_hold_v2", int'(b_hold), 0);
    chk("vs_err", int'(b_err), 0);

    // ---------------- 3-buffer: two swaps then one vsync ----------------
    swap3(2, 1, 0);
    swap3(0, 1, 2);
    c_vs = 1'b0;
    tick();
    chk("flip_cons", int'(c_cons), 2);
    chk("flip_prod", int'(c_prod), 0);
    chk("flip_ready", 3 - int'(c_prod) - int'(c_cons), 1);
    chk("flip_sw", int'(c_sw), 1);
    c_vs = 1'b1;
    tick();
    c_vs = 1'b0;
    tick();
    chk("flip_none_sw", int'(c_sw), 0);
    chk("flip_none_cons", int'(c_cons), 2);
    c_vs = 1'b1;
    tick();
    do_reset();

    // ---------------- 3-buffer: swap and vsync in the same cycle ----------------
    swap3(2, 1, 0);
    swap3(0, 1, 2);
    c_swap = 1'b1;
    tick();
    c_swap = 1'b0;
    tick();
    c_vs = 1'b0;
    tick();
    chk("coin_prod", int'(c_prod), 2);
    chk("coin_cons", int'(c_cons), 0);
    chk("coin_ready", 3 - int'(c_prod) - int'(c_cons), 1);
    chk("coin_sw", int'(c_sw), 1);
    c_vs = 1'b1;
    tick();
    c_vs = 1'b0;
    tick();
    chk("coin_no_flip_sw", int'(c_sw), 0);
    chk("coin_no_flip_cons", int'(c_cons), 0);
    c_vs = 1'b1;
    tick();

    // ---------------- reset asserted during WAIT_VS ----------------
    b_vs = 1'b1;
    tick();
    b_swap = 1'b1;
    tick();
    b_swap = 1'b0;
    repeat (4) tick();
    b_aw = 1'b1;
    tick();
    tick();
    b_aw = 1'b0;
    chk("rstw_out_before", int'(b_out), 2);
    chk("rstw_hold_before", int'(b_hold), 1);
    rst_n = 1'b0;
    #2;
    chk("rstw_prod", int'(b_prod), 0);
    chk("rstw_cons", int'(b_cons), 1);
    chk("rstw_hold", int'(b_hold), 0);
    chk("rstw_sw", int'(b_sw), 0);
    chk("rstw_busy", int'(b_busy), 0);
    chk("rstw_out", int'(b_out), 0);
    chk("rstw_err", int'(b_err), 0);
    chk("rstw_a_err", int'(a_err), 0);
    tick();
    tick();
    chk("rstw_sw_held", int'(b_sw), 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstw_sw_after", int'(b_sw), 0);
    chk("rstw_prod_after", int'(b_prod), 0);
    chk("rstw_hold_after", int'(b_hold), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
